// File: rtl/counter_param.sv
// -----------------------------------------------------------------------------
// counter_param
// Parametrised WIDTH-bit modulo counter with four modes (+STEP, -1, +1, load D).
// The count range is 0..MAX. RCO is a registered wrap pulse and CO is a
// combinational cascade carry, so instances chain into wider or decade
// counters on a single clock.
//
// Build option:
//   COUNTER_RCO_HALF_EN  when defined, RCO is shortened to the half period
//                        between the wrapping rising edge and the next falling
//                        edge. When undefined, RCO lasts one full period and no
//                        falling-edge logic is built.
// -----------------------------------------------------------------------------
module counter_param #(
   parameter int WIDTH = 4,
   parameter int STEP  = 3,
   parameter int MAX   = (1 << WIDTH) - 1
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             ENABLE,
   input  logic             CI,
   input  logic [WIDTH-1:0] D,
   input  logic [1:0]       MODO,
   output logic [WIDTH-1:0] Q,
   output logic             RCO,
   output logic             LOAD,
   output logic             CO
);

   // Constants. The up-count sum is WIDTH+1 bits wide so the carry out of
   // the top bit is never lost, even when MAX is the full binary range.
   localparam logic [WIDTH:0]   L_MAX_X  = (WIDTH+1)'(MAX);
   localparam logic [WIDTH:0]   L_MOD_X  = (WIDTH+1)'(MAX + 1);
   localparam logic [WIDTH:0]   L_STEP_X = (WIDTH+1)'(STEP);
   localparam logic [WIDTH:0]   L_ONE_X  = (WIDTH+1)'(1);
   localparam logic [WIDTH-1:0] L_MAX_W  = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] L_ZERO_W = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] L_ONE_W  = WIDTH'(1);

   localparam logic [1:0] MODE_UP_STEP = 2'b00;
   localparam logic [1:0] MODE_DOWN    = 2'b01;
   localparam logic [1:0] MODE_UP_ONE  = 2'b10;
   localparam logic [1:0] MODE_LOAD    = 2'b11;

   // State
   logic [WIDTH-1:0] r_q;
   logic             r_rco;
   logic             r_load;

   // Next-state and datapath wires
   logic [WIDTH:0]   w_inc;
   logic [WIDTH:0]   w_sum;
   logic             w_up_wrap;
   logic [WIDTH-1:0] w_up_val;
   logic             w_dn_wrap;
   logic [WIDTH-1:0] w_dn_val;
   logic [WIDTH-1:0] w_ld_val;
   logic             w_adv;
   logic             w_term;
   logic [WIDTH-1:0] w_q_nxt;
   logic             w_rco_nxt;
   logic             w_load_nxt;

   // Pick the increment for the two up modes (STEP for 00, one otherwise).
   always_comb begin
      w_inc = L_ONE_X;
      case (MODO)
         MODE_UP_STEP: w_inc = L_STEP_X;
         MODE_UP_ONE:  w_inc = L_ONE_X;
         default:      w_inc = L_ONE_X;
      endcase
   end

   // Up path: anything above MAX wraps, including a forced out-of-range Q.
   assign w_sum     = {1'b0, r_q} + w_inc;
   assign w_up_wrap = (w_sum > L_MAX_X);
   assign w_up_val  = w_up_wrap ? WIDTH'(w_sum - L_MOD_X) : w_sum[WIDTH-1:0];

   // Down path: zero wraps to MAX; any other value, even above MAX, decrements.
   assign w_dn_wrap = (r_q == L_ZERO_W);
   assign w_dn_val  = w_dn_wrap ? L_MAX_W : (r_q - L_ONE_W);

   // Load path saturates at MAX so Q can never leave the legal range.
   assign w_ld_val  = (D > L_MAX_W) ? L_MAX_W : D;

   // Loads need only ENABLE; counting modes also need the cascade carry.
   assign w_adv = ENABLE & (CI | (MODO == MODE_LOAD));

   // Terminal condition for the cascade carry: the value about to wrap.
   always_comb begin
      w_term = 1'b0;
      case (MODO)
         MODE_UP_STEP: w_term = w_up_wrap;
         MODE_UP_ONE:  w_term = w_up_wrap;
         MODE_DOWN:    w_term = w_dn_wrap;
         MODE_LOAD:    w_term = 1'b0;
         default:      w_term = 1'b0;
      endcase
   end

   // The carry goes to the next stage on the same edge, so it is combinational.
   assign CO = ENABLE & CI & w_term;

   // Next-state selection; RCO and LOAD are single-cycle flags, default low.
   always_comb begin
      w_q_nxt    = r_q;
      w_rco_nxt  = 1'b0;
      w_load_nxt = 1'b0;
      if (w_adv) begin
         case (MODO)
            MODE_UP_STEP: begin
               w_q_nxt   = w_up_val;
               w_rco_nxt = w_up_wrap;
            end
            MODE_UP_ONE: begin
               w_q_nxt   = w_up_val;
               w_rco_nxt = w_up_wrap;
            end
            MODE_DOWN: begin
               w_q_nxt   = w_dn_val;
               w_rco_nxt = w_dn_wrap;
            end
            MODE_LOAD: begin
               w_q_nxt    = w_ld_val;
               w_load_nxt = 1'b1;
            end
            default: begin
               w_q_nxt = r_q;
            end
         endcase
      end else begin
         w_q_nxt = r_q;
      end
   end

   // Count, wrap flag and load flag registers; reset clears them at once.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_q    <= L_ZERO_W;
         r_rco  <= 1'b0;
         r_load <= 1'b0;
      end else begin
         r_q    <= w_q_nxt;
         r_rco  <= w_rco_nxt;
         r_load <= w_load_nxt;
      end
   end

   assign Q    = r_q;
   assign LOAD = r_load;

`ifdef COUNTER_RCO_HALF_EN
   logic r_rco_n;

   // Falling-edge copy of the wrap flag; masks RCO after the first half period.
   always_ff @(negedge CLK or posedge RESET) begin
      if (RESET) begin
         r_rco_n <= 1'b0;
      end else begin
         r_rco_n <= r_rco;
      end
   end

   assign RCO = r_rco & ~r_rco_n;
`else
   assign RCO = r_rco;
`endif

endmodule

// File: tb/tb_counter_param.sv
// -----------------------------------------------------------------------------
// tb_counter_param
// Scoreboarded bench for counter_param (WIDTH=4, STEP=3, MAX=9). The stimulus
// process drives one cycle at a time, updates an arithmetic reference model
// and queues the expected Q/RCO/LOAD; a monitor pops and compares after each
// rising edge. Also covers async reset, a two-digit decade chain and the RCO
// width in both builds (COUNTER_RCO_HALF_EN).
// -----------------------------------------------------------------------------
module tb_counter_param;

   localparam int W  = 4;
   localparam int ST = 3;
   localparam int MX = 9;

   logic         CLK = 1'b0;
   logic         RESET;
   logic         ENABLE;
   logic         CI;
   logic [W-1:0] D;
   logic [1:0]   MODO;
   logic [W-1:0] Q;
   logic         RCO, LOAD, CO;

   // chain of two decade stages
   logic         c_rst, c_en, c_ci;
   logic [1:0]   c_modo;
   logic [W-1:0] c_d;
   logic [W-1:0] uq, tq;
   logic         urco, uload, uco, trco, tload, tco;

   typedef struct {
      logic [W-1:0] q;
      logic         rco;
      logic         load;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   m_q    = 0;

   always #5 CLK = ~CLK;

   counter_param #(.WIDTH(W), .STEP(ST), .MAX(MX)) dut (
      .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .CI(CI), .D(D), .MODO(MODO),
      .Q(Q), .RCO(RCO), .LOAD(LOAD), .CO(CO)
   );

   counter_param #(.WIDTH(W), .STEP(ST), .MAX(MX)) u_units (
      .CLK(CLK), .RESET(c_rst), .ENABLE(c_en), .CI(c_ci), .D(c_d), .MODO(c_modo),
      .Q(uq), .RCO(urco), .LOAD(uload), .CO(uco)
   );

   counter_param #(.WIDTH(W), .STEP(ST), .MAX(MX)) u_tens (
      .CLK(CLK), .RESET(c_rst), .ENABLE(c_en), .CI(uco), .D(c_d), .MODO(c_modo),
      .Q(tq), .RCO(trco), .LOAD(tload), .CO(tco)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // One stimulus cycle: drive at the falling edge, predict, queue the result.
   task automatic step(input logic en, input logic ci, input logic [1:0] md, input logic [W-1:0] dv);
      exp_t e;
      int   inc;
      int   n;
      logic co_e;
      @(negedge CLK);
      ENABLE = en; CI = ci; MODO = md; D = dv;
      inc  = (md == 2'b00) ? ST : 1;
      if (md == 2'b01)      co_e = en && ci && (m_q == 0);
      else if (md == 2'b11) co_e = 1'b0;
      else                  co_e = en && ci && (m_q + inc > MX);
      e.rco  = 1'b0;
      e.load = 1'b0;
      if (!en) begin
         e.rco = 1'b0;
      end else if (md == 2'b11) begin
         m_q    = (int'(dv) > MX) ? MX : int'(dv);
         e.load = 1'b1;
      end else if (!ci) begin
         e.rco = 1'b0;
      end else if (md == 2'b01) begin
         if (m_q == 0) begin
            m_q   = MX;
            e.rco = 1'b1;
         end else begin
            m_q = m_q - 1;
         end
      end else begin
         n     = m_q + inc;
         e.rco = (n > MX);
         m_q   = n % (MX + 1);
      end
      e.q = m_q[W-1:0];
      sb.push_back(e);
      #1 check("co", CO, co_e);
   endtask

   // Monitor: compare each modelled cycle, then RCO again after the falling edge.
   initial begin : monitor
      exp_t e;
      logic prev_rco;
      logic want_rise;
      logic want_fall;
      prev_rco = 1'b0;
      forever begin
         @(posedge CLK); #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
`ifdef COUNTER_RCO_HALF_EN
            want_rise = e.rco & ~prev_rco;
            want_fall = 1'b0;
`else
            want_rise = e.rco;
            want_fall = e.rco;
`endif
            prev_rco = e.rco;
            check("q", Q, e.q);
            check("rco", RCO, want_rise);
            check("load", LOAD, e.load);
            @(negedge CLK); #2;
            if (!RESET) check("rco_after_fall", RCO, want_fall);
         end else begin
            prev_rco = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int rco_t;
      int rco_u;
      int waited;
      RESET = 1'b1; ENABLE = 1'b0; CI = 1'b0; MODO = 2'b00; D = '0;
      c_rst = 1'b1; c_en = 1'b0; c_ci = 1'b1; c_modo = 2'b10; c_d = '0;

      // reset state, before any clock edge
      #2;
      check("rst_q", Q, 0);
      check("rst_rco", RCO, 0);
      check("rst_load", LOAD, 0);
      @(negedge CLK); @(negedge CLK);
      RESET = 1'b0;
      m_q = 0;

      // +STEP from 0: 3,6,9,2,5 with a wrap into 2
      repeat (5) step(1'b1, 1'b1, 2'b00, 4'd0);
      @(posedge CLK); #2;
      check("t1_q", Q, 5);

      // down from 0 wraps to 9, then 8
      step(1'b1, 1'b0, 2'b11, 4'd0);
      step(1'b1, 1'b1, 2'b01, 4'd0);
      step(1'b1, 1'b1, 2'b01, 4'd0);

      // saturating load, plain load, +1, load with CI low
      step(1'b1, 1'b1, 2'b11, 4'd12);
      step(1'b1, 1'b1, 2'b11, 4'd4);
      step(1'b1, 1'b1, 2'b10, 4'd0);
      step(1'b1, 1'b0, 2'b11, 4'd7);

      // hold: ENABLE low, then CI low in each counting mode
      repeat (3) step(1'b0, 1'b1, 2'b10, 4'd0);
      step(1'b1, 1'b0, 2'b00, 4'd0);
      step(1'b1, 1'b0, 2'b01, 4'd0);
      step(1'b1, 1'b0, 2'b10, 4'd0);
      @(posedge CLK); #2;
      check("t4_q", Q, 7);

      // reset mid-cycle right after a wrap to 9
      step(1'b1, 1'b0, 2'b11, 4'd0);
      step(1'b1, 1'b1, 2'b01, 4'd0);
      @(posedge CLK); #2;
      check("pre_rst_q", Q, 9);
      check("pre_rst_rco", RCO, 1);
      #1;
      RESET = 1'b1; ENABLE = 1'b0;
      #1;
      check("mid_rst_q", Q, 0);
      check("mid_rst_rco", RCO, 0);
      check("mid_rst_load", LOAD, 0);
      @(negedge CLK); @(negedge CLK);
      RESET = 1'b0;
      m_q = 0;
      step(1'b1, 1'b1, 2'b10, 4'd0);
      @(posedge CLK); #2;
      check("restart_q", Q, 1);

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
              2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      end
      step(1'b0, 1'b0, 2'b00, 4'd0);

      waited = 0;
      while (sb.size() > 0 && waited < 10) begin
         @(posedge CLK); #3;
         waited++;
      end
      check("drain", sb.size(), 0);

      // two-digit decade chain, 100 edges must return to 0:0
      @(negedge CLK);
      c_rst = 1'b0;
      c_en  = 1'b1;
      rco_t = 0;
      rco_u = 0;
      for (int k = 1; k <= 100; k++) begin
         @(posedge CLK); #1;
         check("chain_units", uq, k % 10);
         check("chain_tens", tq, (k / 10) % 10);
         rco_u += int'(urco);
         rco_t += int'(trco);
      end
      @(negedge CLK);
      c_en = 1'b0;
      check("chain_tens_rco_count", rco_t, 1);
      check("chain_units_rco_count", rco_u, 10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
